panel_input_conditioner: RTL and testbench
==========================================

PANEL_INPUT_CONDITIONER -- requirements
Module: panel_input_conditioner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all outputs SHALL be registered state or logic of registered state only.
REQ-002 DEBOUNCE_CYCLES, default 4, is the number of consecutive cycles a synchronized input must differ from its debounced value before the value updates; legal range 1..255.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 raw_door_closed  in  1  asynchronous door switch; 1 = closed.
REQ-006 raw_start_button  in  1  asynchronous start pushbutton; 1 = pressed.
REQ-007 raw_cancel_button  in  1  asynchronous cancel pushbutton; 1 = pressed.
REQ-008 raw_motor_failure, raw_low_water_pressure, raw_sensor_malfunction  in  1 each  asynchronous fault sensors; 1 = fault.
REQ-009 sig_door_closed  out  1  debounced door level.
REQ-010 sig_start_button  out  1  one-cycle start press pulse.
REQ-011 sig_cancel_button  out  1  one-cycle cancel press pulse.
REQ-012 sig_Motor_Failure, sig_Low_Water_Pressure, sig_Sensor_Malfunction  out  1 each  conditioned fault levels.
REQ-013 sig_any_fault  out  1  OR of the three conditioned fault outputs.

Function
REQ-014 Each of the six raw inputs SHALL pass through its own two-flop synchronizer; only the second-stage flop feeds the debouncer.
REQ-015 Each channel SHALL have an 8-bit counter and a debounced level: counter clears to 0 in any cycle where the synchronized value equals the debounced level, and increments otherwise.
REQ-016 The debounced level SHALL take the synchronized value at the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears at that same edge.
REQ-017 Latency: a raw change held stable SHALL appear at the debounced level after the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1 (edge 6 at default).
REQ-018 A synchronized excursion shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged and clear the counter on return.
REQ-019 sig_start_button and sig_cancel_button SHALL be high for exactly the first cycle in which the respective debounced level is 1 (rising edge of the debounced level); release produces no pulse.
REQ-020 If the start and cancel debounced levels rise in the same cycle, only sig_cancel_button SHALL pulse.
REQ-021 sig_start_button SHALL not pulse while the cancel debounced level is 1.
REQ-022 A button held indefinitely SHALL produce exactly one pulse; a new pulse requires release and re-press, each debounced.
REQ-023 sig_door_closed SHALL equal the door debounced level.

Reset
REQ-024 While reset is high at a clock edge, all synchronizer flops, counters, debounced levels and fault latches SHALL clear to 0.
REQ-025 Every output SHALL be 0 in the cycle following a reset edge (door reads open, no pulse, no fault).
REQ-026 Reset asserted mid-debounce SHALL discard counter progress; a button held through reset deassertion SHALL pulse once after full debounce latency.

Configuration
REQ-027 Macro FAULT_LATCH_EN: when defined, each fault output SHALL set on its debounced rising edge and stay 1 until reset, regardless of the raw input.
REQ-028 Without FAULT_LATCH_EN, each fault output SHALL equal its debounced level and fall when the fault clears after debounce.

Verification
REQ-029 Default params, raw_start_button 0->1 held 20 cycles -> sig_start_button high for exactly one cycle, at edge 6 after first sampling edge; no further pulse.
REQ-030 raw_door_closed 0->1 for 3 cycles then 0 (DEBOUNCE_CYCLES=4) -> sig_door_closed stays 0 throughout.
REQ-031 raw_start_button and raw_cancel_button rise on the same edge, held 10 cycles -> sig_cancel_button pulses once, sig_start_button never pulses.
REQ-032 raw_motor_failure high 10 cycles then low 20 cycles -> with FAULT_LATCH_EN sig_Motor_Failure and sig_any_fault stay 1 until reset; without it they fall 6 edges after the raw fall.
REQ-033 reset asserted 2 edges into a start debounce, released, raw_start_button still held -> no pulse during or before reset; one pulse 6 edges after reset release.
REQ-034 raw_door_closed toggling every cycle for 50 cycles from 1 (debounced 1) -> sig_door_closed stays 1 throughout.

Source files
------------

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: two-flop synchronizers, per-channel
// debouncers, press-pulse generation for the start/cancel buttons and
// conditioned fault levels.
// Build option: define FAULT_LATCH_EN to make each fault output sticky
// until reset; when it is undefined, fault outputs follow their debounced levels.
module panel_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_door_closed,
  input  logic raw_start_button,
  input  logic raw_cancel_button,
  input  logic raw_motor_failure,
  input  logic raw_low_water_pressure,
  input  logic raw_sensor_malfunction,
  output logic sig_door_closed,
  output logic sig_start_button,
  output logic sig_cancel_button,
  output logic sig_Motor_Failure,
  output logic sig_Low_Water_Pressure,
  output logic sig_Sensor_Malfunction,
  output logic sig_any_fault
);

  localparam int unsigned N_CH      = 6;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned N_FAULT   = 3;
  localparam int unsigned CH_DOOR   = 0;
  localparam int unsigned CH_START  = 1;
  localparam int unsigned CH_CANCEL = 2;
  localparam int unsigned CH_MOTOR  = 3;
  localparam int unsigned CH_WATER  = 4;
  localparam int unsigned CH_SENSOR = 5;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [N_CH-1:0]    raw_vec;
  logic [N_CH-1:0]    sync1_q;
  logic [N_CH-1:0]    sync2_q;
  logic [N_CH-1:0]    deb_q;
  logic [N_CH-1:0]    deb_next;
  logic [CNT_W-1:0]   cnt_q    [N_CH];
  logic [CNT_W-1:0]   cnt_next [N_CH];

  logic [N_FAULT-1:0] fault_q;
  logic [N_FAULT-1:0] fault_next;
  logic               any_fault_q;
  logic               start_pulse_q;
  logic               start_pulse_next;
  logic               cancel_pulse_q;
  logic               cancel_pulse_next;

  assign raw_vec = {raw_sensor_malfunction, raw_low_water_pressure, raw_motor_failure,
                    raw_cancel_button, raw_start_button, raw_door_closed};

  // Debounce counters: count cycles the synchronized value disagrees with the
  // debounced level; adopt the new value on the cycle the count would hit target.
  always_comb begin
    deb_next = deb_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_next[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if ((cnt_q[i] + CNT_ONE) == CNT_TARGET) begin
          deb_next[i] = sync2_q[i];
        end else begin
          cnt_next[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Press pulses on debounced rising edges; cancel wins over start.
  always_comb begin
    cancel_pulse_next = deb_next[CH_CANCEL] & ~deb_q[CH_CANCEL];
    start_pulse_next  = deb_next[CH_START] & ~deb_q[CH_START] & ~deb_next[CH_CANCEL];
  end

  // Fault conditioning: sticky on rising edge, or transparent to the debounced level.
  always_comb begin
`ifdef FAULT_LATCH_EN
    fault_next = fault_q | (deb_next[CH_SENSOR:CH_MOTOR] & ~deb_q[CH_SENSOR:CH_MOTOR]);
`else
    fault_next = deb_next[CH_SENSOR:CH_MOTOR];
`endif
  end

  // State registers: synchronizers, debouncers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      fault_q        <= '0;
      any_fault_q    <= 1'b0;
      start_pulse_q  <= 1'b0;
      cancel_pulse_q <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q        <= raw_vec;
      sync2_q        <= sync1_q;
      deb_q          <= deb_next;
      fault_q        <= fault_next;
      any_fault_q    <= |fault_next;
      start_pulse_q  <= start_pulse_next;
      cancel_pulse_q <= cancel_pulse_next;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign sig_door_closed        = deb_q[CH_DOOR];
  assign sig_start_button       = start_pulse_q;
  assign sig_cancel_button      = cancel_pulse_q;
  assign sig_Motor_Failure      = fault_q[CH_MOTOR - CH_MOTOR];
  assign sig_Low_Water_Pressure = fault_q[CH_WATER - CH_MOTOR];
  assign sig_Sensor_Malfunction = fault_q[CH_SENSOR - CH_MOTOR];
  assign sig_any_fault          = any_fault_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Self-checking bench for panel_input_conditioner: directed scenarios plus
// randomized inputs compared every cycle against a sample-window reference model.
module tb_panel_input_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HLEN = DEB + 1;

  logic clock;
  logic reset;
  logic raw_door_closed;
  logic raw_start_button;
  logic raw_cancel_button;
  logic raw_motor_failure;
  logic raw_low_water_pressure;
  logic raw_sensor_malfunction;
  logic sig_door_closed;
  logic sig_start_button;
  logic sig_cancel_button;
  logic sig_Motor_Failure;
  logic sig_Low_Water_Pressure;
  logic sig_Sensor_Malfunction;
  logic sig_any_fault;

  int checks = 0;
  int errors = 0;

  // Reference model state: per channel, the values captured by the first
  // synchronizer stage at recent edges (index 0 = most recent).
  bit       hist [6][HLEN];
  bit [5:0] m_deb;
  bit       m_start_p;
  bit       m_cancel_p;
  bit [2:0] m_fault;

  panel_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .raw_door_closed        (raw_door_closed),
    .raw_start_button       (raw_start_button),
    .raw_cancel_button      (raw_cancel_button),
    .raw_motor_failure      (raw_motor_failure),
    .raw_low_water_pressure (raw_low_water_pressure),
    .raw_sensor_malfunction (raw_sensor_malfunction),
    .sig_door_closed        (sig_door_closed),
    .sig_start_button       (sig_start_button),
    .sig_cancel_button      (sig_cancel_button),
    .sig_Motor_Failure      (sig_Motor_Failure),
    .sig_Low_Water_Pressure (sig_Low_Water_Pressure),
    .sig_Sensor_Malfunction (sig_Sensor_Malfunction),
    .sig_any_fault          (sig_any_fault)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: a channel flips once the debouncer has
  // seen DEB consecutive synchronized samples opposite to its current level.
  task automatic model_step(input bit rst, input bit [5:0] raw);
    bit [5:0] nd;
    bit       all_opp;
    if (rst) begin
      for (int c = 0; c < 6; c++)
        for (int k = 0; k < int'(HLEN); k++) hist[c][k] = 1'b0;
      m_deb = '0; m_start_p = 1'b0; m_cancel_p = 1'b0; m_fault = '0;
      return;
    end
    nd = m_deb;
    for (int c = 0; c < 6; c++) begin
      all_opp = 1'b1;
      for (int k = 1; k <= int'(DEB); k++)
        if (hist[c][k] == m_deb[c]) all_opp = 1'b0;
      if (all_opp) nd[c] = ~m_deb[c];
      for (int k = int'(HLEN) - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raw[c];
    end
    m_cancel_p = nd[2] & ~m_deb[2];
    m_start_p  = nd[1] & ~m_deb[1] & ~nd[2];
`ifdef FAULT_LATCH_EN
    m_fault = m_fault | nd[5:3];
`else
    m_fault = nd[5:3];
`endif
    m_deb = nd;
  endtask

  // Advance one cycle: model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_step(reset, {raw_sensor_malfunction, raw_low_water_pressure, raw_motor_failure,
                       raw_cancel_button, raw_start_button, raw_door_closed});
    @(negedge clock);
    check_eq("door",   32'(sig_door_closed),        32'(m_deb[0]));
    check_eq("start",  32'(sig_start_button),       32'(m_start_p));
    check_eq("cancel", 32'(sig_cancel_button),      32'(m_cancel_p));
    check_eq("motor",  32'(sig_Motor_Failure),      32'(m_fault[0]));
    check_eq("water",  32'(sig_Low_Water_Pressure), 32'(m_fault[1]));
    check_eq("sensor", 32'(sig_Sensor_Malfunction), 32'(m_fault[2]));
    check_eq("any",    32'(sig_any_fault),          32'(|m_fault));
  endtask

  task automatic clear_raw();
    raw_door_closed = 0; raw_start_button = 0; raw_cancel_button = 0;
    raw_motor_failure = 0; raw_low_water_pressure = 0; raw_sensor_malfunction = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses, at, n, fall_at, any_fall_at, cpulses;
    clock = 1'b0;
    reset = 1'b1;
    clear_raw();
    @(negedge clock);
    do_reset();
    check_eq("rst_door",  32'(sig_door_closed), 0);
    check_eq("rst_start", 32'(sig_start_button), 0);
    check_eq("rst_any",   32'(sig_any_fault), 0);

    // Single start press held: exactly one pulse at edge DEB+2.
    raw_start_button = 1; pulses = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sig_start_button) begin pulses++; at = i; end
    end
    check_eq("s_press_cnt", 32'(pulses), 1);
    check_eq("s_press_edge", 32'(at), 32'(DEB + 2));
    raw_start_button = 0;
    repeat (10) tick();

    // Door glitch shorter than the debounce window is ignored.
    raw_door_closed = 1; n = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) raw_door_closed = 0;
      tick();
      if (sig_door_closed) n++;
    end
    check_eq("door_glitch", 32'(n), 0);

    // Simultaneous start/cancel: cancel wins.
    raw_start_button = 1; raw_cancel_button = 1; pulses = 0; cpulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sig_start_button) pulses++;
      if (sig_cancel_button) cpulses++;
    end
    check_eq("both_cancel", 32'(cpulses), 1);
    check_eq("both_start", 32'(pulses), 0);
    clear_raw();
    repeat (10) tick();

    // Motor fault pulse: high 10, low 20.
    raw_motor_failure = 1;
    repeat (10) tick();
    check_eq("motor_rise", 32'(sig_Motor_Failure), 1);
    check_eq("any_rise", 32'(sig_any_fault), 1);
    raw_motor_failure = 0; fall_at = 0; any_fall_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!sig_Motor_Failure && fall_at == 0) fall_at = i;
      if (!sig_any_fault && any_fall_at == 0) any_fall_at = i;
    end
`ifdef FAULT_LATCH_EN
    check_eq("motor_fall", 32'(fall_at), 0);
    check_eq("any_fall", 32'(any_fall_at), 0);
`else
    check_eq("motor_fall", 32'(fall_at), 32'(DEB + 2));
    check_eq("any_fall", 32'(any_fall_at), 32'(DEB + 2));
`endif
    do_reset();
    check_eq("motor_rst", 32'(sig_Motor_Failure), 0);

    // Reset mid-debounce discards progress; held button pulses once after release.
    raw_start_button = 1; pulses = 0; at = 0;
    tick(); if (sig_start_button) pulses++;
    tick(); if (sig_start_button) pulses++;
    reset = 1; tick(); if (sig_start_button) pulses++;
    reset = 0;
    check_eq("rst_mid_pre", 32'(pulses), 0);
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (sig_start_button) begin pulses++; at = i; end
    end
    check_eq("rst_mid_cnt", 32'(pulses), 1);
    check_eq("rst_mid_edge", 32'(at), 32'(DEB + 2));
    raw_start_button = 0;
    repeat (10) tick();

    // Door chatter from a closed state never drops the debounced level.
    raw_door_closed = 1;
    repeat (10) tick();
    n = 0;
    for (int i = 0; i < 50; i++) begin
      raw_door_closed = ((i % 2) == 0);
      tick();
      if (!sig_door_closed) n++;
    end
    check_eq("door_chatter", 32'(n), 0);
    clear_raw();
    repeat (10) tick();

    // Randomized: slowly varying inputs with bursts of chatter and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit fast;
      fast = ($urandom_range(9) == 0);
      if ($urandom_range(fast ? 1 : 7) == 0) raw_door_closed        = ~raw_door_closed;
      if ($urandom_range(fast ? 1 : 7) == 0) raw_start_button       = ~raw_start_button;
      if ($urandom_range(fast ? 1 : 7) == 0) raw_cancel_button      = ~raw_cancel_button;
      if ($urandom_range(fast ? 1 : 9) == 0) raw_motor_failure      = ~raw_motor_failure;
      if ($urandom_range(fast ? 1 : 9) == 0) raw_low_water_pressure = ~raw_low_water_pressure;
      if ($urandom_range(fast ? 1 : 9) == 0) raw_sensor_malfunction = ~raw_sensor_malfunction;
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
